// File: rtl/riscv_aes_block_buffer_if.sv
// Engine-side link of the AES block buffer: block offer (valid/ready/data)
// towards the engine and result return (valid/data) from it.
interface riscv_aes_block_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4
);
    logic                            blk_valid_o;
    logic                            blk_ready_i;
    logic [NUM_WORDS*DATA_WIDTH-1:0] blk_data_o;
    logic                            res_valid_i;
    logic [NUM_WORDS*DATA_WIDTH-1:0] res_data_i;

    // buffer side
    modport master (
        output blk_valid_o,
        output blk_data_o,
        input  blk_ready_i,
        input  res_valid_i,
        input  res_data_i
    );

    // engine side
    modport slave (
        input  blk_valid_o,
        input  blk_data_o,
        output blk_ready_i,
        output res_valid_i,
        output res_data_i
    );
endinterface

// File: rtl/riscv_aes_block_buffer.sv
// AES block buffer: collects NUM_WORDS words from the core, offers the full
// block to the engine, captures the result in place for readback or chaining.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | accepting core writes, waiting for start with a full block
// S_ISSUE | block offered to the engine, waiting for blk_ready_i
// S_WAIT  | block taken, waiting for res_valid_i
// S_DONE  | result held in the words; start re-issues, a write reopens
module riscv_aes_block_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4,
    parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    test_en_i,
    input  logic [ADDR_WIDTH-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    wen_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    input  logic                    start_i,
    input  logic                    clear_i,
    output logic                    loaded_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    riscv_aes_block_buffer_if.master eng
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [DATA_WIDTH-1:0]           r_words [NUM_WORDS];
    logic [NUM_WORDS-1:0]            r_mask;
    logic [NUM_WORDS-1:0]            w_asel;
    logic                            w_waddr_ok;
    logic                            w_wen_ok;
    logic                            w_err;
    logic                            r_err;
    logic [NUM_WORDS*DATA_WIDTH-1:0] w_blk;

    // one-hot decode of the write address; no hit means out of range
    always_comb begin
        w_asel = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            w_asel[i] = (waddr_i == ADDR_WIDTH'(i));
        end
    end

    assign w_waddr_ok = |w_asel;
    assign w_wen_ok   = wen_i & w_waddr_ok;
    assign loaded_o   = &r_mask;
    assign err_o      = r_err;

    // block concatenation and read mux; unmatched read addresses give zero
    always_comb begin
        w_blk   = '0;
        rdata_o = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            w_blk[i*DATA_WIDTH +: DATA_WIDTH] = r_words[i];
            if (raddr_i == ADDR_WIDTH'(i)) begin
                rdata_o = r_words[i];
            end
        end
    end

    assign eng.blk_data_o = w_blk;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state logic; test mode and clear both park the FSM in IDLE
    always_comb begin
        w_next = r_state;
        if (test_en_i || clear_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start_i && loaded_o)   w_next = S_ISSUE;
                S_ISSUE: if (eng.blk_ready_i)       w_next = S_WAIT;
                S_WAIT:  if (eng.res_valid_i)       w_next = S_DONE;
                S_DONE: begin
                    // any write request in DONE suppresses a chained start
                    if (w_wen_ok)                   w_next = S_IDLE;
                    else if (start_i && !wen_i)     w_next = S_ISSUE;
                end
                default:                            w_next = S_IDLE;
            endcase
        end
    end

    // state-decoded outputs and illegal-request detection
    always_comb begin
        eng.blk_valid_o = (r_state == S_ISSUE);
        busy_o          = (r_state == S_ISSUE) || (r_state == S_WAIT);
        done_o          = (r_state == S_DONE);
        w_err           = 1'b0;
        if (!test_en_i && !clear_i) begin
            if (wen_i && !w_waddr_ok) w_err = 1'b1;
            case (r_state)
                S_IDLE:         if (start_i && !loaded_o) w_err = 1'b1;
                S_ISSUE, S_WAIT: if (wen_i || start_i)    w_err = 1'b1;
                S_DONE:         if (wen_i && start_i)     w_err = 1'b1;
                default:        ;
            endcase
        end
    end

    // error pulse is registered so it appears the cycle after the request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err;
        end
    end

    // word storage and fill mask
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) r_words[i] <= '0;
            r_mask <= '0;
        end else if (test_en_i) begin
            for (int i = 0; i < NUM_WORDS; i++) r_words[i] <= '1;
            r_mask <= '1;
        end else if (clear_i) begin
            for (int i = 0; i < NUM_WORDS; i++) r_words[i] <= '0;
            r_mask <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    for (int i = 0; i < NUM_WORDS; i++) begin
                        if (wen_i && w_asel[i]) begin
                            r_words[i] <= wdata_i;
                            r_mask[i]  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: if (eng.blk_ready_i) r_mask <= '0;
                S_WAIT: begin
                    if (eng.res_valid_i) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            r_words[i] <= eng.res_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        r_mask <= '1;
                    end
                end
                S_DONE: begin
                    // a write after a result starts a fresh block from that word
                    if (w_wen_ok) begin
                        r_mask <= w_asel;
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            if (w_asel[i]) r_words[i] <= wdata_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_aes_block_buffer.sv
module tb_riscv_aes_block_buffer;
    localparam int DW_A = 32;
    localparam int NW_A = 4;
    localparam int AW_A = 2;
    localparam int DW_B = 64;
    localparam int NW_B = 5;
    localparam int AW_B = 3;

    localparam int PH_IDLE   = 0;
    localparam int PH_OFFER  = 1;
    localparam int PH_AWAIT  = 2;
    localparam int PH_RESULT = 3;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    localparam logic [127:0] Z   = 128'h0;
    localparam logic [127:0] D0  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] R1  = 128'hCAFEF00D_0BADC0DE_FEEDFACE_DEADBEEF;
    localparam logic [127:0] R2  = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] W15 = 128'h00000004_55555555_00000002_00000001;
    localparam logic [127:0] A3  = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] B0  = 128'h000000A3_000000A2_000000A1_000000B0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- DUT A: 4 x 32 ----------------
    logic            a_rst, a_test_en, a_wen, a_start, a_clear;
    logic [AW_A-1:0] a_waddr, a_raddr;
    logic [DW_A-1:0] a_wdata, a_rdata;
    logic            a_loaded, a_busy, a_done, a_err;
    riscv_aes_block_buffer_if #(.DATA_WIDTH(DW_A), .NUM_WORDS(NW_A)) ifa ();

    riscv_aes_block_buffer #(.DATA_WIDTH(DW_A), .NUM_WORDS(NW_A), .ADDR_WIDTH(AW_A)) u_a (
        .clk(clk), .rst(a_rst), .test_en_i(a_test_en),
        .waddr_i(a_waddr), .wdata_i(a_wdata), .wen_i(a_wen),
        .raddr_i(a_raddr), .rdata_o(a_rdata),
        .start_i(a_start), .clear_i(a_clear),
        .loaded_o(a_loaded), .busy_o(a_busy), .done_o(a_done), .err_o(a_err),
        .eng(ifa)
    );

    // ---------------- DUT B: 5 x 64 ----------------
    logic            b_rst, b_test_en, b_wen, b_start, b_clear;
    logic [AW_B-1:0] b_waddr, b_raddr;
    logic [DW_B-1:0] b_wdata, b_rdata;
    logic            b_loaded, b_busy, b_done, b_err;
    riscv_aes_block_buffer_if #(.DATA_WIDTH(DW_B), .NUM_WORDS(NW_B)) ifb ();

    riscv_aes_block_buffer #(.DATA_WIDTH(DW_B), .NUM_WORDS(NW_B), .ADDR_WIDTH(AW_B)) u_b (
        .clk(clk), .rst(b_rst), .test_en_i(b_test_en),
        .waddr_i(b_waddr), .wdata_i(b_wdata), .wen_i(b_wen),
        .raddr_i(b_raddr), .rdata_o(b_rdata),
        .start_i(b_start), .clear_i(b_clear),
        .loaded_o(b_loaded), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
        .eng(ifb)
    );

    // ---------------- comparison helpers ----------------
    task automatic cmp1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic cmpw(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model for DUT A ----------------
    // The block as a plain array of words, a per-word "written" flag and an
    // abstract phase of the transaction with the engine.
    logic [31:0] m_word [NW_A];
    bit          m_fill [NW_A];
    int          m_phase;
    bit          m_err;

    task automatic model_step();
        bit full;
        bit bad;
        int wa;
        full = 1'b1;
        for (int i = 0; i < NW_A; i++) if (!m_fill[i]) full = 1'b0;
        wa  = int'(a_waddr);
        bad = a_wen && (wa >= NW_A);
        m_err = 1'b0;
        if (a_rst) begin
            for (int i = 0; i < NW_A; i++) begin m_word[i] = '0; m_fill[i] = 1'b0; end
            m_phase = PH_IDLE;
        end else if (a_test_en) begin
            for (int i = 0; i < NW_A; i++) begin m_word[i] = '1; m_fill[i] = 1'b1; end
            m_phase = PH_IDLE;
        end else if (a_clear) begin
            for (int i = 0; i < NW_A; i++) begin m_word[i] = '0; m_fill[i] = 1'b0; end
            m_phase = PH_IDLE;
        end else begin
            if (bad) m_err = 1'b1;
            if (m_phase == PH_IDLE) begin
                if (a_wen && !bad) begin m_word[wa] = a_wdata; m_fill[wa] = 1'b1; end
                if (a_start) begin
                    if (full) m_phase = PH_OFFER;
                    else      m_err   = 1'b1;
                end
            end else if (m_phase == PH_OFFER) begin
                if (a_wen || a_start) m_err = 1'b1;
                if (ifa.blk_ready_i) begin
                    m_phase = PH_AWAIT;
                    for (int i = 0; i < NW_A; i++) m_fill[i] = 1'b0;
                end
            end else if (m_phase == PH_AWAIT) begin
                if (a_wen || a_start) m_err = 1'b1;
                if (ifa.res_valid_i) begin
                    for (int i = 0; i < NW_A; i++) begin
                        m_word[i] = ifa.res_data_i[i*32 +: 32];
                        m_fill[i] = 1'b1;
                    end
                    m_phase = PH_RESULT;
                end
            end else begin
                if (a_wen) begin
                    if (!bad) begin
                        for (int i = 0; i < NW_A; i++) m_fill[i] = 1'b0;
                        m_word[wa] = a_wdata;
                        m_fill[wa] = 1'b1;
                        m_phase    = PH_IDLE;
                    end
                    if (a_start) m_err = 1'b1;
                end else if (a_start) begin
                    m_phase = PH_OFFER;
                end
            end
        end
    endtask

    task automatic check_model(input string t);
        logic [127:0] eb;
        bit full;
        full = 1'b1;
        for (int i = 0; i < NW_A; i++) begin
            eb[i*32 +: 32] = m_word[i];
            if (!m_fill[i]) full = 1'b0;
        end
        cmp1({t, ".loaded"}, a_loaded, full);
        cmp1({t, ".busy"},   a_busy,   (m_phase == PH_OFFER) || (m_phase == PH_AWAIT));
        cmp1({t, ".done"},   a_done,   m_phase == PH_RESULT);
        cmp1({t, ".err"},    a_err,    m_err);
        cmp1({t, ".valid"},  ifa.blk_valid_o, m_phase == PH_OFFER);
        cmpw({t, ".blk"},    320'(ifa.blk_data_o), 320'(eb));
        cmpw({t, ".rdata"},  320'(a_rdata), 320'(m_word[int'(a_raddr)]));
    endtask

    task automatic a_idle();
        a_test_en = 1'b0; a_wen = 1'b0; a_start = 1'b0; a_clear = 1'b0;
        a_waddr = '0; a_wdata = '0; a_raddr = '0;
        ifa.blk_ready_i = 1'b0; ifa.res_valid_i = 1'b0; ifa.res_data_i = '0;
    endtask

    task automatic tick_a();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_zero_a(input string t);
        cmp1({t, ".loaded"}, a_loaded, 1'b0);
        cmp1({t, ".busy"},   a_busy,   1'b0);
        cmp1({t, ".done"},   a_done,   1'b0);
        cmp1({t, ".err"},    a_err,    1'b0);
        cmp1({t, ".valid"},  ifa.blk_valid_o, 1'b0);
        cmpw({t, ".blk"},    320'(ifa.blk_data_o), 320'(0));
        for (int r = 0; r < NW_A; r++) begin
            a_raddr = AW_A'(r);
            #1;
            cmpw($sformatf("%s.rdata%0d", t, r), 320'(a_rdata), 320'(0));
        end
        a_raddr = '0;
    endtask

    task automatic fill_a(input string t);
        for (int i = 0; i < NW_A; i++) begin
            a_idle();
            a_wen = 1'b1; a_waddr = AW_A'(i); a_wdata = $urandom(); a_raddr = AW_A'(i);
            tick_a();
            check_model($sformatf("%s.w%0d", t, i));
        end
        a_idle();
    endtask

    // ---------------- DUT B helpers ----------------
    task automatic b_idle();
        b_test_en = 1'b0; b_wen = 1'b0; b_start = 1'b0; b_clear = 1'b0;
        b_waddr = '0; b_wdata = '0; b_raddr = '0;
        ifb.blk_ready_i = 1'b0; ifb.res_valid_i = 1'b0; ifb.res_data_i = '0;
    endtask

    task automatic tick_b();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [319:0] rnd320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit           wen;
        logic [1:0]   waddr;
        logic [31:0]  wdata;
        bit           start;
        bit           clear;
        bit           ready;
        bit           resv;
        logic [127:0] res;
        logic [1:0]   raddr;
        bit           e_loaded;
        bit           e_busy;
        bit           e_done;
        bit           e_err;
        bit           e_valid;
        logic [31:0]  e_rdata;
        logic [127:0] e_blk;
    } vec_t;

    function automatic vec_t v(
        input bit wen, input logic [1:0] wa, input logic [31:0] wd,
        input bit st, input bit cl, input bit rdy, input bit rv, input logic [127:0] rs,
        input logic [1:0] ra,
        input bit el, input bit eb, input bit ed, input bit ee, input bit ev,
        input logic [31:0] erd, input logic [127:0] eblk);
        vec_t x;
        x.wen = wen; x.waddr = wa; x.wdata = wd; x.start = st; x.clear = cl;
        x.ready = rdy; x.resv = rv; x.res = rs; x.raddr = ra;
        x.e_loaded = el; x.e_busy = eb; x.e_done = ed; x.e_err = ee; x.e_valid = ev;
        x.e_rdata = erd; x.e_blk = eblk;
        return x;
    endfunction

    vec_t tbl[$];
    logic [63:0]  bw [NW_B];
    logic [319:0] bexp;
    logic [319:0] bres;

    initial begin
        //           wen wa    wdata          st cl rdy rv res raddr  ld bsy dn er vl  rdata          blk
        tbl.push_back(v(T, 2'd0, 32'h11111111, F, F, F, F, Z,  2'd0,  F, F, F, F, F, 32'h11111111, 128'h00000000_00000000_00000000_11111111));
        tbl.push_back(v(T, 2'd1, 32'h22222222, F, F, F, F, Z,  2'd1,  F, F, F, F, F, 32'h22222222, 128'h00000000_00000000_22222222_11111111));
        tbl.push_back(v(T, 2'd2, 32'h33333333, F, F, F, F, Z,  2'd2,  F, F, F, F, F, 32'h33333333, 128'h00000000_33333333_22222222_11111111));
        tbl.push_back(v(T, 2'd3, 32'h44444444, F, F, F, F, Z,  2'd3,  T, F, F, F, F, 32'h44444444, D0));
        tbl.push_back(v(F, 2'd0, 32'h0,        T, F, F, F, Z,  2'd0,  T, T, F, F, T, 32'h11111111, D0));
        tbl.push_back(v(F, 2'd0, 32'h0,        F, F, F, F, Z,  2'd0,  T, T, F, F, T, 32'h11111111, D0));
        tbl.push_back(v(F, 2'd0, 32'h0,        F, F, F, F, Z,  2'd0,  T, T, F, F, T, 32'h11111111, D0));
        tbl.push_back(v(F, 2'd0, 32'h0,        F, F, F, F, Z,  2'd0,  T, T, F, F, T, 32'h11111111, D0));
        tbl.push_back(v(F, 2'd0, 32'h0,        F, F, T, F, Z,  2'd0,  F, T, F, F, F, 32'h11111111, D0));
        tbl.push_back(v(T, 2'd1, 32'h99999999, F, F, F, F, Z,  2'd1,  F, T, F, T, F, 32'h22222222, D0));
        tbl.push_back(v(F, 2'd0, 32'h0,        F, F, F, T, R1, 2'd0,  T, F, T, F, F, 32'hDEADBEEF, R1));
        tbl.push_back(v(F, 2'd0, 32'h0,        T, F, F, F, Z,  2'd3,  T, T, F, F, T, 32'hCAFEF00D, R1));
        tbl.push_back(v(F, 2'd0, 32'h0,        F, F, T, F, Z,  2'd3,  F, T, F, F, F, 32'hCAFEF00D, R1));
        tbl.push_back(v(F, 2'd0, 32'h0,        F, F, F, T, R2, 2'd2,  T, F, T, F, F, 32'h00000003, R2));
        tbl.push_back(v(T, 2'd2, 32'h55555555, F, F, F, F, Z,  2'd2,  F, F, F, F, F, 32'h55555555, W15));
        tbl.push_back(v(F, 2'd0, 32'h0,        T, F, F, F, Z,  2'd2,  F, F, F, T, F, 32'h55555555, W15));
        tbl.push_back(v(F, 2'd0, 32'h0,        F, F, F, F, Z,  2'd0,  F, F, F, F, F, 32'h00000001, W15));
        tbl.push_back(v(F, 2'd0, 32'h0,        F, T, F, F, Z,  2'd0,  F, F, F, F, F, 32'h00000000, Z));
        tbl.push_back(v(T, 2'd0, 32'h000000A0, F, F, F, F, Z,  2'd0,  F, F, F, F, F, 32'h000000A0, 128'h000000A0));
        tbl.push_back(v(T, 2'd1, 32'h000000A1, F, F, F, F, Z,  2'd1,  F, F, F, F, F, 32'h000000A1, 128'h000000A1_000000A0));
        tbl.push_back(v(T, 2'd2, 32'h000000A2, F, F, F, F, Z,  2'd2,  F, F, F, F, F, 32'h000000A2, 128'h000000A2_000000A1_000000A0));
        tbl.push_back(v(F, 2'd0, 32'h0,        T, F, F, F, Z,  2'd2,  F, F, F, T, F, 32'h000000A2, 128'h000000A2_000000A1_000000A0));
        tbl.push_back(v(T, 2'd3, 32'h000000A3, T, F, F, F, Z,  2'd3,  T, F, F, T, F, 32'h000000A3, A3));
        tbl.push_back(v(T, 2'd0, 32'h000000B0, T, F, F, F, Z,  2'd0,  T, T, F, F, T, 32'h000000B0, B0));
        tbl.push_back(v(F, 2'd0, 32'h0,        T, F, F, F, Z,  2'd0,  T, T, F, T, T, 32'h000000B0, B0));
        tbl.push_back(v(F, 2'd0, 32'h0,        F, T, T, F, Z,  2'd0,  F, F, F, F, F, 32'h00000000, Z));
        tbl.push_back(v(F, 2'd0, 32'h0,        F, F, F, T, R1, 2'd0,  F, F, F, F, F, 32'h00000000, Z));

        a_idle(); b_idle();
        a_rst = 1'b1; b_rst = 1'b1;
        tick_a(); tick_a();
        check_zero_a("rst");
        a_rst = 1'b0; b_rst = 1'b0;

        // ---- directed table on DUT A (model stepped alongside to stay in sync)
        foreach (tbl[k]) begin
            a_idle();
            a_wen = tbl[k].wen; a_waddr = tbl[k].waddr; a_wdata = tbl[k].wdata;
            a_start = tbl[k].start; a_clear = tbl[k].clear; a_raddr = tbl[k].raddr;
            ifa.blk_ready_i = tbl[k].ready; ifa.res_valid_i = tbl[k].resv;
            ifa.res_data_i = tbl[k].res;
            tick_a();
            cmp1($sformatf("v%0d.loaded", k), a_loaded, tbl[k].e_loaded);
            cmp1($sformatf("v%0d.busy", k),   a_busy,   tbl[k].e_busy);
            cmp1($sformatf("v%0d.done", k),   a_done,   tbl[k].e_done);
            cmp1($sformatf("v%0d.err", k),    a_err,    tbl[k].e_err);
            cmp1($sformatf("v%0d.valid", k),  ifa.blk_valid_o, tbl[k].e_valid);
            cmpw($sformatf("v%0d.rdata", k),  320'(a_rdata), 320'(tbl[k].e_rdata));
            cmpw($sformatf("v%0d.blk", k),    320'(ifa.blk_data_o), 320'(tbl[k].e_blk));
        end
        a_idle();

        // ---- test mode for one cycle in the middle of WAIT
        fill_a("tm");
        a_start = 1'b1; tick_a(); check_model("tm.start");
        a_idle(); ifa.blk_ready_i = 1'b1; tick_a(); check_model("tm.hs");
        a_idle(); a_test_en = 1'b1; a_wen = 1'b1; a_start = 1'b1; tick_a();
        a_idle();
        cmp1("tm.loaded", a_loaded, 1'b1);
        cmp1("tm.busy", a_busy, 1'b0);
        cmp1("tm.err", a_err, 1'b0);
        for (int r = 0; r < NW_A; r++) begin
            a_raddr = AW_A'(r);
            #1;
            cmpw($sformatf("tm.rdata%0d", r), 320'(a_rdata), 320'(32'hFFFFFFFF));
        end
        a_raddr = '0;
        check_model("tm.after");

        // ---- reset while a result is held
        a_start = 1'b1; tick_a(); check_model("rd.issue");
        a_idle(); ifa.blk_ready_i = 1'b1; tick_a(); check_model("rd.wait");
        a_idle(); ifa.res_valid_i = 1'b1; ifa.res_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick_a();
        a_idle();
        cmp1("rd.done", a_done, 1'b1);
        a_rst = 1'b1; tick_a(); a_rst = 1'b0;
        check_zero_a("rd");
        a_start = 1'b1; tick_a(); a_idle();
        cmp1("rd.start_err", a_err, 1'b1);
        cmp1("rd.start_valid", ifa.blk_valid_o, 1'b0);
        tick_a();

        // ---- reset while offering the block
        fill_a("ri");
        a_start = 1'b1; tick_a(); a_idle();
        cmp1("ri.valid", ifa.blk_valid_o, 1'b1);
        a_rst = 1'b1; ifa.blk_ready_i = 1'b1; tick_a(); a_rst = 1'b0; a_idle();
        check_zero_a("ri");
        check_model("ri.model");

        // ---- randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            a_idle();
            a_rst     = ($urandom_range(0, 199) == 0);
            a_test_en = ($urandom_range(0, 99) < 2);
            a_clear   = ($urandom_range(0, 99) < 3);
            a_wen     = ($urandom_range(0, 99) < 40);
            a_waddr   = AW_A'($urandom_range(0, NW_A - 1));
            a_wdata   = $urandom();
            a_start   = ($urandom_range(0, 99) < 25);
            a_raddr   = AW_A'($urandom_range(0, NW_A - 1));
            ifa.blk_ready_i = ($urandom_range(0, 99) < 50);
            ifa.res_valid_i = ($urandom_range(0, 99) < 35);
            ifa.res_data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick_a();
            check_model($sformatf("rnd%0d", c));
        end
        a_rst = 1'b0;
        a_idle();

        // ---- DUT B: 5 x 64, non-power-of-two word count
        for (int i = 0; i < NW_B; i++) begin
            bw[i] = {$urandom(), $urandom()};
            bexp[i*64 +: 64] = bw[i];
        end
        for (int i = 0; i < NW_B; i++) begin
            b_idle(); b_wen = 1'b1; b_waddr = AW_B'(i); b_wdata = bw[i];
            tick_b();
            cmp1($sformatf("b.w%0d.err", i), b_err, 1'b0);
            cmp1($sformatf("b.w%0d.loaded", i), b_loaded, i == NW_B - 1);
        end
        for (int a = NW_B; a < 8; a++) begin
            b_idle(); b_wen = 1'b1; b_waddr = AW_B'(a); b_wdata = 64'hBADBADBADBADBAD0;
            tick_b();
            cmp1($sformatf("b.bad%0d.err", a), b_err, 1'b1);
            cmpw($sformatf("b.bad%0d.blk", a), ifb.blk_data_o, bexp);
        end
        b_idle(); tick_b();
        cmp1("b.err_clear", b_err, 1'b0);
        for (int r = 0; r < 8; r++) begin
            b_raddr = AW_B'(r);
            #1;
            cmpw($sformatf("b.rdata%0d", r), 320'(b_rdata), (r < NW_B) ? 320'(bw[r]) : 320'(0));
        end
        b_idle(); b_start = 1'b1; tick_b(); b_idle();
        cmp1("b.issue.valid", ifb.blk_valid_o, 1'b1);
        cmp1("b.issue.busy", b_busy, 1'b1);
        cmpw("b.issue.blk", ifb.blk_data_o, bexp);
        ifb.blk_ready_i = 1'b1; tick_b(); b_idle();
        cmp1("b.wait.busy", b_busy, 1'b1);
        cmp1("b.wait.valid", ifb.blk_valid_o, 1'b0);
        cmp1("b.wait.loaded", b_loaded, 1'b0);
        bres = rnd320();
        ifb.res_valid_i = 1'b1; ifb.res_data_i = bres; tick_b(); b_idle();
        cmp1("b.done", b_done, 1'b1);
        cmp1("b.done.busy", b_busy, 1'b0);
        cmp1("b.done.loaded", b_loaded, 1'b1);
        cmpw("b.done.blk", ifb.blk_data_o, bres);
        for (int r = 0; r < NW_B; r++) begin
            b_raddr = AW_B'(r);
            #1;
            cmpw($sformatf("b.res%0d", r), 320'(b_rdata), 320'(bres[r*64 +: 64]));
        end
        b_idle(); b_start = 1'b1; tick_b(); b_idle();
        cmp1("b.chain.valid", ifb.blk_valid_o, 1'b1);
        cmp1("b.chain.done", b_done, 1'b0);
        cmpw("b.chain.blk", ifb.blk_data_o, bres);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
